pricing_host_tx: RTL and testbench

//  Host-side driver for the option-pricing core's narrow command bus (state[1:0], in[11:0], out[15:0]).

---
 rtl/pricing_pkg.sv | 22 ++
 rtl/pricing_host_tx_if.sv | 31 +++
 rtl/pricing_host_tx.sv | 126 ++++++++++++
 tb/tb_pricing_host_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pricing_pkg.sv
// Command encodings and bus widths shared by the host-side driver and the
// core-side command decoder of the option-pricing core.
package pricing_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_READ = 2'b11;

  localparam int PARAM_W = 12;
  localparam int PRICE_W = 16;

  // One shared down-counter times LOAD (4 beats), WAIT and READ, so it must fit the largest.
  function automatic int cnt_width(input int run_cycles, input int read_lat);
    int w;
    w = $clog2(run_cycles + 1);
    if ($clog2(read_lat + 1) > w) w = $clog2(read_lat + 1);
    if (w < 2) w = 2;
    return w;
  endfunction

endpackage

// File: rtl/pricing_host_tx_if.sv
// Job handshake, result handshake and narrow core command bus of pricing_host_tx.
// slave is the driver block itself; master is whatever feeds jobs and models the core.
interface pricing_host_tx_if
  import pricing_pkg::*;
();

  logic               job_valid;
  logic               job_ready;
  logic [PARAM_W-1:0] s0;
  logic [PARAM_W-1:0] k;
  logic [PARAM_W-1:0] w;
  logic [PARAM_W-1:0] q;
  logic [1:0]         core_state;
  logic [PARAM_W-1:0] core_in;
  logic [PRICE_W-1:0] core_out;
  logic               res_valid;
  logic               res_ready;
  logic [PRICE_W-1:0] price;
  logic               busy;

  modport master (
    output job_valid, s0, k, w, q, res_ready, core_out,
    input  job_ready, core_state, core_in, res_valid, price, busy
  );

  modport slave (
    input  job_valid, s0, k, w, q, res_ready, core_out,
    output job_ready, core_state, core_in, res_valid, price, busy
  );

endinterface

// File: rtl/pricing_host_tx.sv
// Host-side driver for the option-pricing core: serialises one parameter set as
// LOAD beats, issues RUN, waits a fixed compute time, READs the price and returns it.
module pricing_host_tx
  import pricing_pkg::*;
#(
  parameter int RUN_CYCLES = 1024,
  parameter int READ_LAT   = 2
) (
  input logic              clk,
  input logic              rst,
  pricing_host_tx_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_READ,
    ST_HOLD
  } state_t;

  localparam int CNT_W = cnt_width(RUN_CYCLES, READ_LAT);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PARAM_W-1:0] p_k;
  logic [PARAM_W-1:0] p_w;
  logic [PARAM_W-1:0] p_q;
  logic [1:0]         core_state_r;
  logic [PARAM_W-1:0] core_in_r;
  logic [PRICE_W-1:0] price_r;
  logic               res_valid_r;
  logic               job_ready_r;
  logic               busy_r;

  // S0 goes straight to core_in on accept; K, w, q shift down one slot per LOAD beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      p_k          <= '0;
      p_w          <= '0;
      p_q          <= '0;
      core_state_r <= CMD_IDLE;
      core_in_r    <= '0;
      price_r      <= '0;
      res_valid_r  <= 1'b0;
      job_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.job_valid) begin
            state        <= ST_LOAD;
            core_state_r <= CMD_LOAD;
            core_in_r    <= bus.s0;
            p_k          <= bus.k;
            p_w          <= bus.w;
            p_q          <= bus.q;
            cnt          <= CNT_W'(3);
            job_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
          end
        end
        ST_LOAD: begin
          p_k <= p_w;
          p_w <= p_q;
          p_q <= '0;
          if (cnt == '0) begin
            state        <= ST_RUN;
            core_state_r <= CMD_RUN;
            core_in_r    <= '0;
          end else begin
            core_in_r <= p_k;
            cnt       <= cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          state        <= ST_WAIT;
          core_state_r <= CMD_IDLE;
          cnt          <= CNT_W'(RUN_CYCLES - 1);
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state        <= ST_READ;
            core_state_r <= CMD_READ;
            cnt          <= CNT_W'(READ_LAT - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_READ: begin
          // The price is taken at the edge that ends the last READ beat.
          if (cnt == '0) begin
            state        <= ST_HOLD;
            core_state_r <= CMD_IDLE;
            price_r      <= bus.core_out;
            res_valid_r  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            state       <= ST_IDLE;
            res_valid_r <= 1'b0;
            job_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.core_state = core_state_r;
  assign bus.core_in    = core_in_r;
  assign bus.price      = price_r;
  assign bus.res_valid  = res_valid_r;
  assign bus.job_ready  = job_ready_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_pricing_host_tx.sv
// Scoreboard bench for pricing_host_tx: jobs push expected bus beats and prices,
// a negedge monitor pops and compares them; a small core model drives core_out.
module tb_pricing_host_tx;
  import pricing_pkg::*;

  localparam int RC  = 8;
  localparam int RL  = 2;
  localparam int LAT = 4 + 1 + RC + RL;

  typedef struct {
    logic [1:0]  st;
    logic [11:0] data;
    bit          chk_data;
  } beat_t;

  typedef struct {
    logic [15:0] price;
    int          acc_edge;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   hs_edge = -10;
  int   run_edge = 0;
  logic [15:0] rv_first;
  logic [15:0] rv_last;

  beat_t exp_beats[$];
  res_t  exp_res[$];

  pricing_host_tx_if bus_if ();

  pricing_host_tx #(
    .RUN_CYCLES(RC),
    .READ_LAT  (RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core model: a different word may be presented on each READ beat.
  initial begin
    int rd_idx;
    rd_idx = 0;
    forever begin
      @(negedge clk);
      if (bus_if.core_state == CMD_READ) begin
        bus_if.core_out = (rd_idx < RL - 1) ? rv_first : rv_last;
        rd_idx++;
      end else begin
        bus_if.core_out = 16'hDEAD;
        rd_idx = 0;
      end
    end
  end

  // Monitor: compares every non-idle beat, WAIT length, result latency and price.
  initial begin
    logic       prev_rv;
    logic [1:0] prev_st;
    beat_t      b;
    res_t       r;
    prev_rv = 1'b0;
    prev_st = CMD_IDLE;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rv = 1'b0;
        prev_st = CMD_IDLE;
      end else begin
        if (bus_if.core_state != CMD_IDLE) begin
          if (exp_beats.size() == 0) begin
            checkOutput("unexpected_beat", 32'(bus_if.core_state), 32'(CMD_IDLE));
          end else begin
            b = exp_beats.pop_front();
            checkOutput("beat_state", 32'(bus_if.core_state), 32'(b.st));
            if (b.chk_data) checkOutput("beat_data", 32'(bus_if.core_in), 32'(b.data));
            if (bus_if.core_state == CMD_RUN) run_edge = cyc;
            if (bus_if.core_state == CMD_READ && prev_st != CMD_READ)
              checkOutput("wait_len", 32'(cyc - run_edge), 32'(RC + 1));
          end
        end
        if (bus_if.res_valid && !prev_rv) begin
          if (exp_res.size() == 0) checkOutput("unexpected_result", 32'(bus_if.res_valid), 32'd0);
          else checkOutput("latency", 32'(cyc - exp_res[0].acc_edge), 32'(LAT));
        end
        if (bus_if.res_valid && bus_if.res_ready) begin
          if (exp_res.size() == 0) begin
            checkOutput("unexpected_handshake", 32'(bus_if.res_valid), 32'd0);
          end else begin
            r = exp_res.pop_front();
            checkOutput("price", 32'(bus_if.price), 32'(r.price));
          end
          hs_edge = cyc + 1;
        end
        prev_rv = bus_if.res_valid;
        prev_st = bus_if.core_state;
      end
    end
  end

  task automatic applyStimulus(input logic [11:0] s0, input logic [11:0] k, input logic [11:0] w,
                               input logic [11:0] q, input logic [15:0] exp_price,
                               input bit drop_valid, output int acc);
    int    n;
    beat_t b;
    res_t  r;
    @(negedge clk);
    bus_if.s0 = s0;
    bus_if.k  = k;
    bus_if.w  = w;
    bus_if.q  = q;
    bus_if.job_valid = 1'b1;
    n = 0;
    while (!bus_if.job_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checkOutput("accept_timeout", 32'(bus_if.job_ready), 32'd1);
      bus_if.job_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      b.chk_data = 1'b1;
      b.st = CMD_LOAD;
      b.data = s0; exp_beats.push_back(b);
      b.data = k;  exp_beats.push_back(b);
      b.data = w;  exp_beats.push_back(b);
      b.data = q;  exp_beats.push_back(b);
      b.st = CMD_RUN;
      b.data = 12'h000; exp_beats.push_back(b);
      b.st = CMD_READ;
      b.chk_data = 1'b0;
      for (int i = 0; i < RL; i++) exp_beats.push_back(b);
      r.price = exp_price;
      r.acc_edge = acc;
      exp_res.push_back(r);
      checkOutput("job_ready_after_accept", 32'(bus_if.job_ready), 32'd0);
      checkOutput("busy_after_accept", 32'(bus_if.busy), 32'd1);
      if (drop_valid) bus_if.job_valid = 1'b0;
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while ((exp_res.size() != 0 || exp_beats.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) checkOutput("result_timeout", 32'(exp_res.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_core_state"}, 32'(bus_if.core_state), 32'(CMD_IDLE));
    checkOutput({tag, "_core_in"}, 32'(bus_if.core_in), 32'd0);
    checkOutput({tag, "_price"}, 32'(bus_if.price), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(bus_if.res_valid), 32'd0);
    checkOutput({tag, "_job_ready"}, 32'(bus_if.job_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    int acc_a;
    int acc_b;
    int n;
    bus_if.job_valid = 1'b0;
    bus_if.s0 = '0;
    bus_if.k  = '0;
    bus_if.w  = '0;
    bus_if.q  = '0;
    bus_if.res_ready = 1'b1;
    bus_if.core_out = '0;
    rv_first = 16'h1234;
    rv_last  = 16'h1234;

    // Reset and idle
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkResetOutputs("reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_core_state", 32'(bus_if.core_state), 32'(CMD_IDLE));
      checkOutput("idle_job_ready", 32'(bus_if.job_ready), 32'd1);
      checkOutput("idle_res_valid", 32'(bus_if.res_valid), 32'd0);
    end

    // Basic job
    applyStimulus(12'h800, 12'h7A0, 12'h010, 12'h033, 16'h1234, 1'b1, acc_a);
    waitDone();
    checkOutput("after_job_busy", 32'(bus_if.busy), 32'd0);

    // Consumer stalls the result for 10 cycles
    bus_if.res_ready = 1'b0;
    rv_first = 16'h0BEE;
    rv_last  = 16'h0BEE;
    applyStimulus(12'h123, 12'h456, 12'h789, 12'hABC, 16'h0BEE, 1'b1, acc_a);
    n = 0;
    while (!bus_if.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hold_res_valid_seen", 32'(bus_if.res_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_res_valid", 32'(bus_if.res_valid), 32'd1);
      checkOutput("hold_price", 32'(bus_if.price), 32'h0BEE);
      checkOutput("hold_core_state", 32'(bus_if.core_state), 32'(CMD_IDLE));
      checkOutput("hold_busy", 32'(bus_if.busy), 32'd1);
    end
    @(posedge clk);
    #1 bus_if.res_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_res_valid", 32'(bus_if.res_valid), 32'd0);
    checkOutput("release_job_ready", 32'(bus_if.job_ready), 32'd1);
    waitDone();

    // job_valid held high across two jobs
    rv_first = 16'h1234;
    rv_last  = 16'h1234;
    applyStimulus(12'h111, 12'h222, 12'h333, 12'h444, 16'h1234, 1'b0, acc_a);
    applyStimulus(12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 16'h1234, 1'b1, acc_b);
    checkOutput("b2b_accept_edge", 32'(acc_b), 32'(hs_edge + 1));
    waitDone();
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_b2b_idle", 32'(bus_if.core_state), 32'(CMD_IDLE));
    end

    // Reset in the middle of WAIT
    applyStimulus(12'h321, 12'h654, 12'h987, 12'hCBA, 16'h1234, 1'b1, acc_a);
    while (cyc < acc_a + 9) @(negedge clk);
    rst = 1'b1;
    #1 checkResetOutputs("midjob_reset");
    exp_beats.delete();
    exp_res.delete();
    @(negedge clk) rst = 1'b0;
    rv_first = 16'h4321;
    rv_last  = 16'h4321;
    applyStimulus(12'h0F0, 12'h00F, 12'hF00, 12'h5A5, 16'h4321, 1'b1, acc_a);
    waitDone();

    // core_out changes on every READ beat
    rv_first = 16'hAAAA;
    rv_last  = 16'h5B5B;
    applyStimulus(12'h001, 12'h002, 12'h003, 12'h004, 16'h5B5B, 1'b1, acc_a);
    waitDone();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
